// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between the fetch (IF)
// and data (MEM) requesters. Data wins ties; a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants taken while a fetch
// was waiting. Requests are held on the memory port until acknowledged,
// read data is returned with a one-cycle ready pulse, and the pipeline
// stall is derived combinationally from the requests and ready pulses.
module mem_arbiter #(
    parameter int STARVE_MAX = 4  // legal range 1..255
) (
    input  logic        clk_i,
    input  logic        rst_i,        // asynchronous, active low

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,

    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,

    output logic        stall_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_e      state_q,     state_d;
    logic [7:0]  starve_q,    starve_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_data_q,   if_data_d;
    logic [31:0] dm_rdata_q,  dm_rdata_d;
    logic        if_ready_q,  if_ready_d;
    logic        dm_ready_q,  dm_ready_d;

    logic        pick_i;
    logic        pick_d;

    // Arbitration: data has priority unless the fetch has waited through
    // STARVE_MAX data grants in a row.
    always_comb begin
        pick_i = if_req_i & (~dm_req_i | (starve_q == STARVE_LIM));
        pick_d = dm_req_i & ~pick_i;
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_i) begin
                    state_d     = GRANT_I;
                    starve_d    = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = 32'd0;
                end else if (pick_d) begin
                    state_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    // Only data grants that overtake a waiting fetch count.
                    if (if_req_i && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
            end

            GRANT_I: begin
                if (mem_ack_i) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if_data_d  = mem_rdata_i;
                    if_ready_d = 1'b1;
                end
            end

            GRANT_D: begin
                if (mem_ack_i) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    // Writes leave the last read value in place.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    dm_ready_d = 1'b1;
                end
            end

            // One dead cycle so the requester's updated request is seen
            // before the next arbitration.
            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            starve_q    <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_data_q   <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign if_ready_o  = if_ready_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ready_o  = dm_ready_q;
    assign busy_o      = (state_q != IDLE);
    assign stall_o     = (if_req_i & ~if_ready_q) | (dm_req_i & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each directed test pushes its expected
// memory grants and ready responses, a negedge monitor pops and compares.
module tb_mem_arbiter;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;     // expected first cycle of mem_req_o
    } gnt_t;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          cyc;     // expected ready-pulse cycle
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = 32'd0;
    logic [31:0] dm_wdata_i = 32'd0;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o;
    logic        busy_o;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mem_lat = 0;
    int   wcnt = 0;
    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    logic        prev_req = 1'b0;
    logic        h_we = 1'b0;
    logic [31:0] h_addr = 32'd0;
    logic [31:0] h_wdata = 32'd0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.STARVE_MAX(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .busy_o(busy_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_ready(input bit is_if, input string nm);
        bit got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(posedge clk_i);
            #1;
            got = is_if ? if_ready_o : dm_ready_o;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no ready pulse within 60 cycles", nm);
        end
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Memory model: acks mem_lat cycles after mem_req_o first shows high.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (mem_req_o) begin
            if (wcnt == mem_lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
                wcnt        = 0;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hBAD0_0000;
                wcnt++;
            end
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_0000;
            wcnt        = 0;
        end
    end

    // Monitor: grants, hold-until-ack, and ready responses.
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            if (mem_req_o && !prev_req) begin
                if (exp_gnt.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL gnt_unexpected: addr %h, want no grant (cycle %0d)", mem_addr_o, cyc);
                end else begin
                    gnt_t g;
                    g = exp_gnt.pop_front();
                    chk("gnt_addr", mem_addr_o, g.addr);
                    chk("gnt_we", 32'(mem_we_o), 32'(g.we));
                    chk("gnt_wdata", mem_wdata_o, g.wdata);
                    if (g.cyc >= 0) chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                end
                h_we    = mem_we_o;
                h_addr  = mem_addr_o;
                h_wdata = mem_wdata_o;
            end else if (mem_req_o) begin
                chk("hold_addr", mem_addr_o, h_addr);
                chk("hold_we", 32'(mem_we_o), 32'(h_we));
                chk("hold_wdata", mem_wdata_o, h_wdata);
            end
            if (mem_req_o) begin
                chk("stall_grant", 32'(stall_o), 32'd1);
                chk("busy_grant", 32'(busy_o), 32'd1);
            end
            if (if_ready_o || dm_ready_o) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: if_ready %b dm_ready %b, want none (cycle %0d)",
                             if_ready_o, dm_ready_o, cyc);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_which", 32'(if_ready_o), 32'(r.is_if));
                    chk("rsp_data", r.is_if ? if_data_o : dm_rdata_o, r.data);
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rsp_stall", 32'(stall_o), 32'(r.is_if ? dm_req_i : if_req_i));
                    chk("rsp_busy", 32'(busy_o), 32'd1);
                end
            end
        end
        prev_req = mem_req_o;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int b;
        int rel;

        // Reset values.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_if_ready", 32'(if_ready_o), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b1;

        // Fetch, zero wait.
        @(posedge clk_i); #1;
        b = cyc;
        mem_lat = 0;
        exp_gnt.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, cyc: b + 1});
        exp_rsp.push_back('{is_if: 1'b1, data: 32'hDEADBEEF, cyc: b + 2});
        if_req_i = 1'b1; if_addr_i = 32'h10;
        wait_ready(1'b1, "fetch_ready");
        if_req_i = 1'b0;

        // Conflict: data first, fetch three cycles later.
        @(posedge clk_i); #1;
        b = cyc;
        exp_gnt.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, cyc: b + 1});
        exp_gnt.push_back('{we: 1'b0, addr: 32'h20,  wdata: 32'h0, cyc: b + 4});
        exp_rsp.push_back('{is_if: 1'b0, data: 32'h0200C0DE, cyc: b + 2});
        exp_rsp.push_back('{is_if: 1'b1, data: 32'h0020C0DE, cyc: b + 5});
        fork
            begin
                if_req_i = 1'b1; if_addr_i = 32'h20;
                wait_ready(1'b1, "conflict_if_ready");
                if_req_i = 1'b0;
            end
            begin
                dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200; dm_wdata_i = 32'h0;
                wait_ready(1'b0, "conflict_dm_ready");
                dm_req_i = 1'b0;
            end
        join

        // Starvation with STARVE_MAX=2: D, D, I, D.
        @(posedge clk_i); #1;
        b = cyc;
        exp_gnt.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, cyc: b + 1});
        exp_gnt.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, cyc: b + 4});
        exp_gnt.push_back('{we: 1'b0, addr: 32'h40,  wdata: 32'h0, cyc: b + 7});
        exp_gnt.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0, cyc: b + 10});
        exp_rsp.push_back('{is_if: 1'b0, data: 32'h0100C0DE, cyc: b + 2});
        exp_rsp.push_back('{is_if: 1'b0, data: 32'h0104C0DE, cyc: b + 5});
        exp_rsp.push_back('{is_if: 1'b1, data: 32'h0040C0DE, cyc: b + 8});
        exp_rsp.push_back('{is_if: 1'b0, data: 32'h0108C0DE, cyc: b + 11});
        fork
            begin
                if_req_i = 1'b1; if_addr_i = 32'h40;
                wait_ready(1'b1, "starve_if_ready");
                if_req_i = 1'b0;
            end
            begin
                dm_req_i = 1'b1; dm_we_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    dm_addr_i = 32'h100 + 32'(4 * k);
                    wait_ready(1'b0, "starve_dm_ready");
                end
                dm_req_i = 1'b0;
            end
        join

        // Write with two wait cycles: read-data register must keep 0x0108C0DE.
        @(posedge clk_i); #1;
        b = cyc;
        mem_lat = 2;
        exp_gnt.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h12345678, cyc: b + 1});
        exp_rsp.push_back('{is_if: 1'b0, data: 32'h0108C0DE, cyc: b + 4});
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h12345678;
        wait_ready(1'b0, "write_ready");
        dm_req_i = 1'b0; dm_we_i = 1'b0;

        // Long latency fetch: ack 10 cycles after mem_req_o.
        @(posedge clk_i); #1;
        b = cyc;
        mem_lat = 10;
        exp_gnt.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0, cyc: b + 1});
        exp_rsp.push_back('{is_if: 1'b1, data: 32'h0044C0DE, cyc: b + 12});
        if_req_i = 1'b1; if_addr_i = 32'h44;
        wait_ready(1'b1, "long_ready");
        if_req_i = 1'b0;

        // Reset in GRANT_D before the ack: abandoned, then re-granted.
        @(posedge clk_i); #1;
        b = cyc;
        mem_lat = 5;
        exp_gnt.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, cyc: b + 1});
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_wdata_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("midrst_if_data", if_data_o, 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        rel = cyc;
        exp_gnt.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, cyc: rel + 1});
        exp_rsp.push_back('{is_if: 1'b0, data: 32'h0300C0DE, cyc: rel + 7});
        wait_ready(1'b0, "midrst_ready");
        dm_req_i = 1'b0;

        repeat (4) @(posedge clk_i);
        #1;
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("gnt_queue_left", 32'(exp_gnt.size()), 32'd0);
        chk("rsp_queue_left", 32'(exp_rsp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares one multi-cycle memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage pipeline. It arbitrates, holds stable requests on the memory port until acknowledged, returns read data with a one-cycle ready pulse, and drives the pipeline stall. Data accesses have priority. A starvation counter guarantees that fetch progresses.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits. Legal range 1..255.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request; held until if_ready_o.
- if_addr_i  in  32  fetch address; stable while if_req_i is high.
- if_data_o  out  32  fetched word; registered.
- if_ready_o  out  1  one-cycle pulse; if_data_o is valid.
- dm_req_i  in  1  data request; held until dm_ready_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  32  data address.
- dm_wdata_i  in  32  write data.
- dm_rdata_o  out  32  read data; registered.
- dm_ready_o  out  1  one-cycle pulse; access done.
- mem_req_o  out  1  memory request; registered.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data; valid with mem_ack_i.
- mem_ack_i  in  1  memory completion; one cycle per request.
- stall_o  out  1  pipeline stall: (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o). Combinational.
- busy_o  out  1  high in any state except IDLE.

## Operation
- The FSM has four states: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE, arbitration:
  - Only one requester active: grant it.
  - Both active: grant D, unless starve_cnt == STARVE_MAX, in which case grant I.
  - On grant, register mem_addr_o, mem_we_o and mem_wdata_o, set mem_req_o=1, and move to GRANT_I or GRANT_D.
  - For I grants, mem_we_o=0 and mem_wdata_o=0.
- GRANT_x:
  - mem_req_o and all mem_* fields are held constant until mem_ack_i.
  - On the ack edge: mem_req_o goes to 0 and the FSM moves to RESP.
  - Read grant: mem_rdata_i is captured into if_data_o or dm_rdata_o.
  - Write grant: dm_rdata_o is unchanged.
  - The matching ready output is set to 1.
- RESP:
  - The ready pulse is high for exactly this cycle.
  - Next state is IDLE, unconditionally, so the requester's post-ready request update is sampled before re-arbitration.
- starve_cnt (8-bit):
  - Cleared on every I grant.
  - Incremented on a D grant when if_req_i=1 at grant time; saturates at STARVE_MAX.
  - Unchanged on a D grant when if_req_i=0.
- A requester dropping req during GRANT/RESP is a protocol violation. The transaction still completes and pulses ready.
- mem_ack_i outside GRANT_x is ignored.
- Data-output registers hold their values until overwritten by a later read of the same requester.

## Timing
- Reset (rst_i low) acts immediately, regardless of clock:
  - state = IDLE, starve_cnt = 0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0.
  - if_data_o, dm_rdata_o = 0.
  - if_ready_o, dm_ready_o = 0.
  - An in-flight transaction is abandoned with no ready pulse; it is re-arbitrated after release.
- With the FSM in IDLE at cycle t and a request sampled at t:
  - mem_req_o = 1 in cycle t+1.
  - Earliest mem_ack_i is t+1.
  - Ready pulse in cycle t+2.
  - Back-to-back service rate: one access per 3 cycles plus memory wait cycles.
- stall_o follows the requests combinationally and is low in the RESP cycle of the served requester.
- The mem_* outputs change only on the grant edge and the ack edge.

## Test plan
- Fetch, zero wait: if_req_i=1, if_addr_i=0x10 at cycle 0; mem_ack_i=1, mem_rdata_i=0xDEADBEEF at cycle 1.
  - Required: mem_req_o=1 and mem_addr_o=0x10 at cycle 1; if_ready_o=1 and if_data_o=0xDEADBEEF at cycle 2 only.
- Conflict: if_req_i and dm_req_i (read, 0x200) both rise at cycle 0, memory acks one cycle after each request.
  - Required: mem_addr_o sequence 0x200 then the fetch address; dm_ready_o precedes if_ready_o by 3 cycles.
- Starvation: STARVE_MAX=2, fetch held at 0x40, data re-requests 0x100, 0x104, 0x108 after each ready.
  - Required: grant order D(0x100), D(0x104), I(0x40), D(0x108).
- Write: dm_we_i=1, dm_addr_i=0x80, dm_wdata_i=0x12345678.
  - Required: mem_we_o=1 and mem_wdata_o=0x12345678 until ack; dm_ready_o pulses once; dm_rdata_o keeps its previous value.
- Long latency: ack 10 cycles after mem_req_o.
  - Required: mem_addr_o, mem_we_o, mem_wdata_o constant and stall_o=1 for all 10 cycles; ready one cycle after the ack.
- Reset mid-grant: rst_i low in GRANT_D before ack.
  - Required: mem_req_o=0 immediately, no dm_ready_o pulse; after release the held request is granted with the same address.
